// File: rtl/serial_cla_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: one 4-bit carry-lookahead slice per cycle, LSB first.
// Optional macro ADD_MODE_EN adds an in_op port selecting add (1) or subtract (0).
module serial_cla_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef ADD_MODE_EN
  input  logic             in_op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int MSB    = WIDTH - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // in_ready is a pure function of state, so out_ready never reaches it combinationally.

  logic             op_add;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

`ifdef ADD_MODE_EN
  assign op_add = in_op;
`else
  assign op_add = 1'b0;
`endif

  logic [CW+1:0]    sh;
  logic [3:0]       x, y, p, g, s;
  logic [4:0]       c;
  logic [WIDTH-1:0] diff_new;

  // bx_q holds the operand actually added (b inverted for subtract).
  always_comb begin
    sh   = {cnt_q, 2'b00};
    x    = 4'(a_q >> sh);
    y    = 4'(bx_q >> sh);
    p    = x ^ y;
    g    = x & y;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
    diff_new = (diff_q & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(s) << sh);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    bx_d     = bx_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          bx_d    = op_add ? in_b : ~in_b;
          carry_d = ~op_add;
          sub_d   = ~op_add;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        diff_d  = diff_new;
        carry_d = c[4];
        if (cnt_q == CW'(NSLICE - 1)) begin
          state_d  = S_DONE;
          borrow_d = sub_q ? ~c[4] : c[4];
          // Comparing a with the effective addend covers both add and subtract overflow.
          ovf_d    = (a_q[MSB] == bx_q[MSB]) && (diff_new[MSB] != a_q[MSB]);
          zero_d   = (diff_new == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      bx_q     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      bx_q     <= bx_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_diff   = diff_q;
  assign out_borrow = borrow_q;
  assign out_ovf    = ovf_q;
  assign out_zero   = zero_q;

endmodule
